// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage of the 5-stage pipeline, between the EX/MEM and MEM/WB
//   registers. Non-memory instructions pass straight through in one cycle.
//   Loads and stores run over a req/ack data-memory port. While an access is
//   outstanding, stall freezes IF..EX and the EX/MEM register.
//
// Ports
//   clk, rst          pipeline clock (rising edge), async active-high reset
//   exmem*            instruction currently in MEM (held stable while stall=1)
//   dmemReq/We/Addr/Wdata/Be   registered request, held for the whole access
//   dmemRdata/dmemAck          single-cycle completion with read data
//   stall             combinational: hold upstream stages this cycle
//   memwbRd/Wb/Data   MEM/WB register read by write-back and forwarding
//   memErr            sticky misalign/timeout flag, cleared only by rst
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  exmemRd,
  input  logic [31:0] exmemAlu,
  input  logic [31:0] exmemReg2,
  input  logic        exmemWb,
  input  logic        exmemMemRead,
  input  logic        exmemMemWrite,
  input  logic [2:0]  exmemFunc3,
  input  logic [31:0] dmemRdata,
  input  logic        dmemAck,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemBe,
  output logic        stall,
  output logic [4:0]  memwbRd,
  output logic        memwbWb,
  output logic [31:0] memwbData,
  output logic        memErr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          ld_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;

  logic          memop;
  logic [1:0]    off;
  logic          is_byte;
  logic          is_half;
  logic          misalign;
  logic          last;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;

  // Pick the byte/half lane at the latched offset and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h000000, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0000, h};
      default: load_ext = rdata;
    endcase
  endfunction

  // Decode access size, alignment and byte-lane placement of the store data.
  always_comb begin
    memop   = exmemMemRead | exmemMemWrite;
    off     = exmemAlu[1:0];
    is_byte = (exmemFunc3 == 3'b000) || (exmemFunc3 == 3'b100);
    is_half = (exmemFunc3 == 3'b001) || (exmemFunc3 == 3'b101);
    if (is_byte) begin
      misalign   = 1'b0;
      be_next    = 4'b0001 << off;
      wdata_next = {4{exmemReg2[7:0]}};
    end else if (is_half) begin
      misalign   = off[0];
      be_next    = off[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{exmemReg2[15:0]}};
    end else begin
      // unsupported func3 values fall through to a word access
      misalign   = (off != 2'b00);
      be_next    = 4'b1111;
      wdata_next = exmemReg2;
    end
  end

  // Stall while a request is being launched or is still waiting on ack.
  always_comb begin
    last = (count == CW'(TIMEOUT - 1));
    if (rst) begin
      stall = 1'b0;
    end else if (state == IDLE) begin
      stall = memop & ~misalign;
    end else begin
      stall = ~dmemAck & ~last;
    end
  end

  // Access FSM, request register and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      ld_q      <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      dmemReq   <= 1'b0;
      dmemWe    <= 1'b0;
      dmemAddr  <= 32'h0000_0000;
      dmemWdata <= 32'h0000_0000;
      dmemBe    <= 4'b0000;
      memwbRd   <= 5'd0;
      memwbWb   <= 1'b0;
      memwbData <= 32'h0000_0000;
      memErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && !misalign) begin
            state     <= BUSY;
            count     <= '0;
            ld_q      <= exmemMemRead;
            off_q     <= off;
            f3_q      <= exmemFunc3;
            dmemReq   <= 1'b1;
            // a load wins when both read and write are set
            dmemWe    <= exmemMemWrite & ~exmemMemRead;
            dmemAddr  <= {exmemAlu[31:2], 2'b00};
            dmemWdata <= wdata_next;
            dmemBe    <= be_next;
            memwbRd   <= 5'd0;
            memwbWb   <= 1'b0;
            memwbData <= 32'h0000_0000;
          end else if (memop) begin
            memErr    <= 1'b1;
            memwbRd   <= 5'd0;
            memwbWb   <= 1'b0;
            memwbData <= 32'h0000_0000;
          end else begin
            memwbRd   <= exmemRd;
            memwbWb   <= exmemWb;
            memwbData <= exmemAlu;
          end
        end
        BUSY: begin
          if (dmemAck) begin
            // ack on the timeout cycle still completes normally
            state     <= IDLE;
            count     <= '0;
            dmemReq   <= 1'b0;
            memwbRd   <= exmemRd;
            memwbWb   <= exmemWb;
            memwbData <= ld_q ? load_ext(dmemRdata, off_q, f3_q) : exmemAlu;
          end else if (last) begin
            state     <= IDLE;
            count     <= '0;
            dmemReq   <= 1'b0;
            memErr    <= 1'b1;
            memwbRd   <= 5'd0;
            memwbWb   <= 1'b0;
            memwbData <= 32'h0000_0000;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          count   <= '0;
          dmemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver pushes expected requests
// and retirements computed from a byte-array memory model; a responder and a
// monitor pop and compare as the DUT presents them.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exmemRd;
  logic [31:0] exmemAlu, exmemReg2;
  logic        exmemWb, exmemMemRead, exmemMemWrite;
  logic [2:0]  exmemFunc3;
  logic [31:0] dmemRdata;
  logic        dmemAck;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemBe;
  logic        stall;
  logic [4:0]  memwbRd;
  logic        memwbWb;
  logic [31:0] memwbData;
  logic        memErr;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .exmemRd(exmemRd), .exmemAlu(exmemAlu), .exmemReg2(exmemReg2),
    .exmemWb(exmemWb), .exmemMemRead(exmemMemRead), .exmemMemWrite(exmemMemWrite),
    .exmemFunc3(exmemFunc3), .dmemRdata(dmemRdata), .dmemAck(dmemAck),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemBe(dmemBe), .stall(stall),
    .memwbRd(memwbRd), .memwbWb(memwbWb), .memwbData(memwbData), .memErr(memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } ret_t;

  req_t req_q[$];
  ret_t ret_q[$];

  logic [7:0] model_mem [256];
  logic [7:0] resp_mem  [256];
  logic       model_err;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  ack_delay = 0;
  bit  noack = 1'b0;
  bit  active = 1'b0;

  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_nop();
    exmemRd = 5'd0; exmemAlu = 32'h0; exmemReg2 = 32'h0; exmemWb = 1'b0;
    exmemMemRead = 1'b0; exmemMemWrite = 1'b0; exmemFunc3 = 3'b000;
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      model_mem[a + i] = v[8*i +: 8];
      resp_mem[a + i]  = v[8*i +: 8];
    end
  endtask

  // Called at posedge+1; returns after the instruction has been consumed.
  task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic wb, input logic mr, input logic mw, input logic [2:0] f3,
                       input int dly, input bit na);
    int   a, sz, exp_st, st;
    bit   mis, done;
    logic [1:0]  off;
    logic [31:0] ld;
    logic [15:0] h;
    req_t r;
    exmemRd = rd; exmemAlu = alu; exmemReg2 = rs2; exmemWb = wb;
    exmemMemRead = mr; exmemMemWrite = mw; exmemFunc3 = f3;
    ack_delay = dly; noack = na; active = 1'b1;
    off = alu[1:0];
    a   = int'(alu[7:0]);
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    mis = (sz == 2 && off[0]) || (sz == 4 && off != 2'b00);
    exp_st = 0;
    if (!(mr || mw)) begin
      ret_q.push_back('{wb, rd, alu, model_err});
    end else if (mis) begin
      model_err = 1'b1;
      ret_q.push_back('{1'b0, 5'd0, 32'h0, model_err});
    end else begin
      r.addr = {alu[31:2], 2'b00};
      r.we   = mw && !mr;
      if (sz == 1) begin
        r.be = 4'b0001 << off; r.wdata = {4{rs2[7:0]}};
      end else if (sz == 2) begin
        r.be = off[1] ? 4'b1100 : 4'b0011; r.wdata = {2{rs2[15:0]}};
      end else begin
        r.be = 4'b1111; r.wdata = rs2;
      end
      req_q.push_back(r);
      exp_st = na ? TIMEOUT : dly + 1;
      if (na) begin
        model_err = 1'b1;
        ret_q.push_back('{1'b0, 5'd0, 32'h0, model_err});
      end else if (mr) begin
        h = {model_mem[a + 1], model_mem[a]};
        if (sz == 1)
          ld = (f3 == 3'd4) ? {24'h0, model_mem[a]} : {{24{model_mem[a][7]}}, model_mem[a]};
        else if (sz == 2)
          ld = (f3 == 3'd5) ? {16'h0, h} : {{16{h[15]}}, h};
        else
          ld = {model_mem[a + 3], model_mem[a + 2], model_mem[a + 1], model_mem[a]};
        ret_q.push_back('{wb, rd, ld, model_err});
      end else begin
        for (int i = 0; i < sz; i++) model_mem[a + i] = rs2[8*i +: 8];
        ret_q.push_back('{wb, rd, alu, model_err});
      end
    end
    st = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else st++;
    end
    if (!done) begin
      n_fail++;
      $display("FAIL stall_timeout: stall still high after 40 cycles");
    end
    check("stall_cycles", st, exp_st);
    @(posedge clk); #1;
    drive_nop();
    active = 1'b0;
  endtask

  // Memory responder: checks each new request, acks after ack_delay BUSY cycles.
  initial begin
    int   cyc;
    req_t r;
    logic [7:0] wi;
    cyc = 0; dmemAck = 1'b0; dmemRdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dmemAck = 1'b0;
      dmemRdata = $urandom;
      if (dmemReq) begin
        if (cyc == 0) begin
          last_addr = dmemAddr; last_we = dmemWe; last_be = dmemBe; last_wdata = dmemWdata;
          if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: addr 0x%08h with no request expected", dmemAddr);
          end else begin
            r = req_q.pop_front();
            check("req_addr", dmemAddr, r.addr);
            check("req_we", {31'h0, dmemWe}, {31'h0, r.we});
            if (r.we) begin
              check("req_be", {28'h0, dmemBe}, {28'h0, r.be});
              check("req_wdata", dmemWdata, r.wdata);
            end
          end
        end
        if (!noack && cyc == ack_delay) begin
          wi = dmemAddr[7:0];
          dmemAck = 1'b1;
          dmemRdata = {resp_mem[wi + 3], resp_mem[wi + 2], resp_mem[wi + 1], resp_mem[wi]};
          if (dmemWe)
            for (int i = 0; i < 4; i++)
              if (dmemBe[i]) resp_mem[wi + i] = dmemWdata[8*i +: 8];
          cyc = 0;
        end else begin
          cyc++;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  // Retirement monitor: an unstalled cycle retires into MEM/WB at the next edge.
  initial begin
    ret_t e;
    forever begin
      @(negedge clk);
      if (!rst && active && !stall) begin
        @(posedge clk); #1;
        if (ret_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_retire: memwbWb=%0d with nothing expected", memwbWb);
        end else begin
          e = ret_q.pop_front();
          check("memwb_wb", {31'h0, memwbWb}, {31'h0, e.wb});
          if (e.wb) begin
            check("memwb_rd", {27'h0, memwbRd}, {27'h0, e.rd});
            check("memwb_data", memwbData, e.data);
          end
          check("mem_err", {31'h0, memErr}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, {31'h0, dmemReq}, 32'h0);
    check({tag, "_stall"}, {31'h0, stall}, 32'h0);
    check({tag, "_wb"}, {31'h0, memwbWb}, 32'h0);
    check({tag, "_rd"}, {27'h0, memwbRd}, 32'h0);
    check({tag, "_data"}, memwbData, 32'h0);
    check({tag, "_err"}, {31'h0, memErr}, 32'h0);
  endtask

  initial begin
    logic [31:0] v, alu;
    int kind;
    model_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      model_mem[i] = v[7:0];
      resp_mem[i]  = v[7:0];
    end
    drive_nop();
    rst = 1'b1;
    #12;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD passthrough: no stall, 1-cycle retire
    issue(5'd3, 32'h0000_0005, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 0, 1'b0);
    check("add_data", memwbData, 32'h0000_0005);
    // LW, ack 3 cycles after req rises -> 4 stall cycles
    set_word(32'h100, 32'hDEAD_BEEF);
    issue(5'd5, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 3, 1'b0);
    check("lw_data", memwbData, 32'hDEAD_BEEF);
    set_word(32'h100, 32'h80FF_FFFF);
    issue(5'd6, 32'h0000_0103, 32'h0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 1'b0);
    check("lb_data", memwbData, 32'hFFFF_FF80);
    issue(5'd7, 32'h0000_0103, 32'h0, 1'b1, 1'b1, 1'b0, 3'b100, 0, 1'b0);
    check("lbu_data", memwbData, 32'h0000_0080);
    // SH lanes
    issue(5'd0, 32'h0000_0102, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 3'b001, 2, 1'b0);
    check("sh_we", {31'h0, last_we}, 32'h1);
    check("sh_be", {28'h0, last_be}, 32'hC);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    check("sh_addr", last_addr, 32'h0000_0100);
    // ack on the timeout cycle wins: data retired, no error
    issue(5'd8, 32'h0000_0040, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, TIMEOUT - 1, 1'b0);
    check("ack_on_timeout_err", {31'h0, memErr}, 32'h0);
    // both read and write: treated as load, store dropped
    issue(5'd9, 32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b0);
    // misaligned LW
    issue(5'd10, 32'h0000_0101, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 0, 1'b0);
    check("misalign_err", {31'h0, memErr}, 32'h1);
    // timeout
    issue(5'd11, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      alu = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      case (kind)
        0: issue(5'($urandom), alu, $urandom, 1'($urandom), 1'b0, 1'b0, 3'($urandom), 0, 1'b0);
        1: issue(5'($urandom), alu, $urandom, 1'($urandom), 1'b1, 1'b0, 3'($urandom),
                 $urandom_range(0, 4), ($urandom_range(0, 19) == 0));
        2: issue(5'($urandom), alu, $urandom, 1'b0, 1'b0, 1'b1, 3'($urandom),
                 $urandom_range(0, 4), ($urandom_range(0, 19) == 0));
        default: issue(5'($urandom), alu, $urandom, 1'($urandom), 1'b1, 1'b1, 3'($urandom),
                       $urandom_range(0, 4), 1'b0);
      endcase
    end

    // reset pulsed in BUSY cycle 2
    exmemRd = 5'd12; exmemAlu = 32'h0000_0100; exmemWb = 1'b1;
    exmemMemRead = 1'b1; exmemFunc3 = 3'b010; noack = 1'b1;
    req_q.push_back('{32'h0000_0100, 1'b0, 4'b1111, 32'h0});
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    drive_nop();
    #1;
    check_reset_state("midbusy_reset");
    #1;
    rst = 1'b0;
    req_q.delete(); ret_q.delete();
    model_err = 1'b0;
    @(posedge clk); #1;
    set_word(32'h0C0, 32'h1357_9BDF);
    issue(5'd13, 32'h0000_00C0, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 1, 1'b0);
    check("post_reset_lw", memwbData, 32'h1357_9BDF);

    if (req_q.size() != 0 || ret_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: req=%0d ret=%0d", req_q.size(), ret_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
